// File: rtl/color_zone_scheduler_if.sv
// Bus between the color-zone scheduler and its surroundings: shadow-bank config port,
// detector timing/hit inputs, active window outputs and per-zone result report.
interface color_zone_scheduler_if #(
   parameter int unsigned NUM_ZONES = 4,
   parameter int unsigned ZONE_W    = 2,
   parameter int unsigned CNT_W     = 20
);
   logic                 cfg_we;
   logic [ZONE_W+1:0]    cfg_addr;
   logic [7:0]           cfg_wdata;
   logic [NUM_ZONES-1:0] zone_en;
   logic                 det_vsync;
   logic                 det_valid;
   logic                 det_hit;
   logic [7:0]           thr_cb_min;
   logic [7:0]           thr_cb_max;
   logic [7:0]           thr_cr_min;
   logic [7:0]           thr_cr_max;
   logic [ZONE_W-1:0]    cur_zone;
   logic                 zone_active;
   logic                 res_valid;
   logic [ZONE_W-1:0]    res_zone;
   logic [CNT_W-1:0]     res_count;
   logic                 res_sat;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, zone_en, det_vsync, det_valid, det_hit,
      input  thr_cb_min, thr_cb_max, thr_cr_min, thr_cr_max, cur_zone, zone_active,
      input  res_valid, res_zone, res_count, res_sat
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, zone_en, det_vsync, det_valid, det_hit,
      output thr_cb_min, thr_cb_max, thr_cr_min, thr_cr_max, cur_zone, zone_active,
      output res_valid, res_zone, res_count, res_sat
   );
endinterface

// File: rtl/color_zone_scheduler.sv
// Round-robin scheduler sharing one Cb/Cr window detector across several zones, one zone
// per frame; loads the zone window at each vsync rising edge and reports its hit count.
module color_zone_scheduler #(
   parameter int unsigned NUM_ZONES = 4,
   parameter int unsigned ZONE_W    = 2,
   parameter int unsigned CNT_W     = 20
) (
   input logic                   clk,
   input logic                   rst,
   color_zone_scheduler_if.slave bus
);
   typedef enum logic {StIdle, StRun} state_e;

   // Field order matches cfg_addr[1:0]: cb_min, cb_max, cr_min, cr_max.
   localparam logic [3:0][7:0]    ThrRst = {8'd111, 8'd80, 8'd180, 8'd150};
   localparam logic [CNT_W-1:0]   CntMax = {CNT_W{1'b1}};

   state_e                         state_q, state_d;
   logic                           vs_d;
   logic [NUM_ZONES-1:0][3:0][7:0] shadow_q;
   logic [3:0][7:0]                thr_q, thr_d;
   logic [ZONE_W-1:0]              cur_zone_q, cur_zone_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           sat_q, sat_d;
   logic                           res_valid_q, res_valid_d;
   logic [ZONE_W-1:0]              res_zone_q, res_zone_d;
   logic [CNT_W-1:0]               res_count_q, res_count_d;
   logic                           res_sat_q, res_sat_d;
   logic                           bnd, hit;
   logic [ZONE_W-1:0]              first_zone, next_zone, idx;

   assign bnd = bus.det_vsync & ~vs_d;
   assign hit = bus.det_valid & bus.det_hit;

   // Descending scans so the lowest index (or smallest forward distance) wins.
   always_comb begin
      first_zone = '0;
      next_zone  = cur_zone_q;
      idx        = '0;
      for (int i = int'(NUM_ZONES) - 1; i >= 0; i--) begin
         if (bus.zone_en[i]) first_zone = ZONE_W'(i);
      end
      for (int k = int'(NUM_ZONES) - 1; k >= 1; k--) begin
         idx = cur_zone_q + ZONE_W'(k);
         if (bus.zone_en[idx]) next_zone = idx;
      end
   end

   always_comb begin
      state_d     = state_q;
      cur_zone_d  = cur_zone_q;
      thr_d       = thr_q;
      cnt_d       = cnt_q;
      sat_d       = sat_q;
      res_valid_d = 1'b0;
      res_zone_d  = res_zone_q;
      res_count_d = res_count_q;
      res_sat_d   = res_sat_q;
      unique case (state_q)
         StIdle: begin
            if (bnd && (|bus.zone_en)) begin
               state_d    = StRun;
               cur_zone_d = first_zone;
               thr_d      = shadow_q[first_zone];
               cnt_d      = CNT_W'(hit);
               sat_d      = 1'b0;
            end
         end
         StRun: begin
            if (bnd) begin
               res_valid_d = 1'b1;
               res_zone_d  = cur_zone_q;
               res_count_d = cnt_q;
               res_sat_d   = sat_q;
               sat_d       = 1'b0;
               if (|bus.zone_en) begin
                  cur_zone_d = next_zone;
                  thr_d      = shadow_q[next_zone];
                  cnt_d      = CNT_W'(hit);
               end else begin
                  state_d = StIdle;
                  cnt_d   = '0;
               end
            end else if (hit) begin
               if (cnt_q == CntMax) sat_d = 1'b1;
               else                 cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         vs_d        <= 1'b0;
         thr_q       <= ThrRst;
         cur_zone_q  <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_zone_q  <= '0;
         res_count_q <= '0;
         res_sat_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         vs_d        <= bus.det_vsync;
         thr_q       <= thr_d;
         cur_zone_q  <= cur_zone_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         res_valid_q <= res_valid_d;
         res_zone_q  <= res_zone_d;
         res_count_q <= res_count_d;
         res_sat_q   <= res_sat_d;
      end
   end

   // Active load reads shadow_q, so a write on the boundary cycle lands after the load.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int z = 0; z < int'(NUM_ZONES); z++) shadow_q[z] <= ThrRst;
      end else if (bus.cfg_we) begin
         shadow_q[bus.cfg_addr[ZONE_W+1:2]][bus.cfg_addr[1:0]] <= bus.cfg_wdata;
      end
   end

   assign bus.thr_cb_min  = thr_q[0];
   assign bus.thr_cb_max  = thr_q[1];
   assign bus.thr_cr_min  = thr_q[2];
   assign bus.thr_cr_max  = thr_q[3];
   assign bus.cur_zone    = cur_zone_q;
   assign bus.zone_active = (state_q == StRun);
   assign bus.res_valid   = res_valid_q;
   assign bus.res_zone    = res_zone_q;
   assign bus.res_count   = res_count_q;
   assign bus.res_sat     = res_sat_q;
endmodule
